// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the multicycle CPU.
// Accepts one load/store at a time, waits WAIT_CYCLES, then performs a
// byte-enable access to an internal word array and holds the response
// until it is accepted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we                   1 = store, 0 = load
//   req_addr [ADDR_W-1:0]    byte address (word index = req_addr[ADDR_W-1:2])
//   req_be [3:0]             byte-lane enables
//   req_signed               sign-extend load result
//   req_wdata [31:0]         right-aligned store data
//   resp_valid / resp_ready  response handshake
//   resp_rdata [31:0]        right-aligned, extended load data (0 on store/error)
//   resp_err                 illegal byte enable or word index out of range
module dm_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   waitCnt;
  logic               weQ;
  logic [IDX_W-1:0]   idxQ;
  logic [3:0]         beQ;
  logic               signedQ;
  logic [31:0]        wdataQ;

  logic [31:0]        mem [DEPTH];

  logic               beLegal;
  logic               inRange;
  logic               accessOk;
  logic [31:0]        rdWord;
  logic [31:0]        laneMask;
  logic [31:0]        alignedData;
  logic [31:0]        loadData;

  // Byte offset bits never affect the access; lane selection comes from req_be.
  logic unusedAddrBits;
  assign unusedAddrBits = ^req_addr[1:0];

  // Only naturally aligned byte, half and word enables are legal.
  always_comb begin
    beLegal = 1'b0;
    case (beQ)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: beLegal = 1'b1;
      default:                   beLegal = 1'b0;
    endcase
  end

  assign inRange  = 32'(idxQ) < DEPTH;
  assign accessOk = beLegal & inRange;
  assign rdWord   = mem[idxQ[MEM_AW-1:0]];
  assign laneMask = {{8{beQ[3]}}, {8{beQ[2]}}, {8{beQ[1]}}, {8{beQ[0]}}};

  // Replicate right-aligned store data so every enabled lane sees its bytes.
  always_comb begin
    alignedData = {4{wdataQ[7:0]}};
    case (beQ)
      4'b1111:          alignedData = wdataQ;
      4'b0011, 4'b1100: alignedData = {2{wdataQ[15:0]}};
      default:          alignedData = {4{wdataQ[7:0]}};
    endcase
  end

  // Shift the enabled lanes down to bit 0 and extend.
  always_comb begin
    loadData = 32'h0;
    case (beQ)
      4'b0001: loadData = {{24{signedQ & rdWord[7]}},  rdWord[7:0]};
      4'b0010: loadData = {{24{signedQ & rdWord[15]}}, rdWord[15:8]};
      4'b0100: loadData = {{24{signedQ & rdWord[23]}}, rdWord[23:16]};
      4'b1000: loadData = {{24{signedQ & rdWord[31]}}, rdWord[31:24]};
      4'b0011: loadData = {{16{signedQ & rdWord[15]}}, rdWord[15:0]};
      4'b1100: loadData = {{16{signedQ & rdWord[31]}}, rdWord[31:16]};
      4'b1111: loadData = rdWord;
      default: loadData = 32'h0;
    endcase
  end

  // Storage array: no reset; a reset on the EXEC edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && state == EXEC && weQ && accessOk) begin
      mem[idxQ[MEM_AW-1:0]] <= (rdWord & ~laneMask) | (alignedData & laneMask);
    end
  end

  // Transaction sequencer with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      waitCnt    <= '0;
      weQ        <= 1'b0;
      idxQ       <= '0;
      beQ        <= 4'h0;
      signedQ    <= 1'b0;
      wdataQ     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            weQ       <= req_we;
            idxQ      <= req_addr[ADDR_W-1:2];
            beQ       <= req_be;
            signedQ   <= req_signed;
            wdataQ    <= req_wdata;
            waitCnt   <= CNT_W'(WAIT_CYCLES);
            req_ready <= 1'b0;
            state     <= (WAIT_CYCLES == 0) ? EXEC : WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 1'b1;
          if (waitCnt == CNT_W'(1)) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_err   <= ~accessOk;
          resp_rdata <= (accessOk && !weQ) ? loadData : 32'h0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: two instances (2 wait states and 0 wait states),
// a word-array model and a queue of expected responses.
module tb_dm_responder;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;   // 0: two-wait-state instance, 1: zero-wait instance
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = 12'h0;
  logic [3:0]  req_be = 4'h0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_ready = 1'b1;

  logic        v2, v0;
  logic        rdy2, rdy0, rv2, rv0, er2, er0;
  logic [31:0] rd2, rd0;
  logic        rdy, rv, er;
  logic [31:0] rd;

  always #5 clk = ~clk;

  assign v2  = req_valid & ~sel;
  assign v0  = req_valid & sel;
  assign rdy = sel ? rdy0 : rdy2;
  assign rv  = sel ? rv0  : rv2;
  assign rd  = sel ? rd0  : rd2;
  assign er  = sel ? er0  : er2;

  dm_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(rv2), .resp_ready(resp_ready),
    .resp_rdata(rd2), .resp_err(er2)
  );

  dm_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_rdata(rd0), .resp_err(er0)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] modelMem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int lowLane(input logic [3:0] be);
    int lo;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
    return lo;
  endfunction

  // Lane i of the word takes byte (i - lowest lane) of the right-aligned data.
  task automatic modelStore(input logic [11:0] addr, input logic [3:0] be, input logic [31:0] wd);
    int lo;
    int idx;
    lo  = lowLane(be);
    idx = int'(addr[11:2]);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) modelMem[idx][8*i +: 8] = wd[8*(i-lo) +: 8];
    end
  endtask

  function automatic logic [31:0] modelLoad(input logic [31:0] w, input logic [3:0] be, input logic sgn);
    logic [31:0] v;
    logic [31:0] m;
    int          width;
    width = 8 * $countones(be);
    v = w >> (8 * lowLane(be));
    if (width < 32) begin
      m = (32'd1 << width) - 32'd1;
      v = v & m;
      if (sgn && v[width-1]) v = v | ~m;
    end
    return v;
  endfunction

  // One transaction: queue the expected response, drive, then check what comes out.
  task automatic doReq(input logic we, input logic [11:0] addr, input logic [3:0] be,
                       input logic sgn, input logic [31:0] wd, input logic [31:0] expD,
                       input logic expE, input int hold);
    int   n;
    exp_t got;
    expQ.push_back('{d: expD, e: expE});
    if (we && !expE) modelStore(addr, be, wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be;
    req_signed = sgn; req_wdata = wd; resp_ready = (hold == 0);
    n = 0;
    while (!rdy && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_idle", 32'(rdy), 32'd1);
    @(posedge clk);
    #1;
    // Scramble request fields after acceptance; the responder must ignore them.
    req_valid = 1'b0; req_we = ~we; req_addr = 12'($urandom); req_be = 4'($urandom);
    req_signed = ~sgn; req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!rv && n < 300);
    chk("latency", 32'(n - 1), sel ? 32'd1 : 32'd3);
    got = expQ.pop_front();
    chk("rdata", rd, got.d);
    chk("err", 32'(er), 32'(got.e));
    chk("busy_ready", 32'(rdy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h060; req_be = 4'hF;
      req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("hold_valid", 32'(rv), 32'd1);
      chk("hold_rdata", rd, got.d);
      chk("hold_err", 32'(er), 32'(got.e));
      chk("hold_ready", 32'(rdy), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("post_ready", 32'(rdy), 32'd1);
    chk("post_valid", 32'(rv), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [3:0]  legal [7];
    legal[0] = 4'b0001; legal[1] = 4'b0010; legal[2] = 4'b0100; legal[3] = 4'b1000;
    legal[4] = 4'b0011; legal[5] = 4'b1100; legal[6] = 4'b1111;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_valid", 32'(rv), 32'd0);
      chk("rst_rdata", rd, 32'h0);
      chk("rst_err", 32'(er), 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;

    // Give every word a known value so the array can be audited later.
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = $urandom;
      doReq(1'b1, 12'(i * 4), 4'hF, 1'b0, w, 32'h0, 1'b0, 0);
    end
    doReq(1'b1, 12'h020, 4'hF, 1'b0, 32'h11223344, 32'h0, 1'b0, 0);
    doReq(1'b1, 12'h030, 4'hF, 1'b0, 32'h00000000, 32'h0, 1'b0, 0);
    doReq(1'b1, 12'h040, 4'hF, 1'b0, 32'h12345678, 32'h0, 1'b0, 0);

    // Word store/load.
    doReq(1'b1, 12'h010, 4'hF, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    doReq(1'b0, 12'h010, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte merge and extension.
    doReq(1'b1, 12'h020, 4'b0100, 1'b0, 32'h000000F0, 32'h0, 1'b0, 0);
    doReq(1'b0, 12'h020, 4'hF, 1'b0, 32'h0, 32'h11F03344, 1'b0, 0);
    doReq(1'b0, 12'h020, 4'b0100, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b0, 0);
    doReq(1'b0, 12'h020, 4'b0100, 1'b0, 32'h0, 32'h000000F0, 1'b0, 0);

    // Halfword.
    doReq(1'b1, 12'h030, 4'b1100, 1'b0, 32'h00008001, 32'h0, 1'b0, 0);
    doReq(1'b0, 12'h030, 4'hF, 1'b0, 32'h0, 32'h80010000, 1'b0, 0);
    doReq(1'b0, 12'h030, 4'b1100, 1'b1, 32'h0, 32'hFFFF8001, 1'b0, 0);
    doReq(1'b0, 12'h030, 4'b0011, 1'b1, 32'h0, 32'h00000000, 1'b0, 0);

    // Every legal lane pattern, both extensions, against the model.
    doReq(1'b1, 12'h0A0, 4'hF, 1'b0, 32'h807F_FF01, 32'h0, 1'b0, 0);
    for (int b = 0; b < 7; b++) begin
      for (int s = 0; s < 2; s++) begin
        doReq(1'b0, 12'h0A0, legal[b], s[0], 32'h0,
              modelLoad(modelMem[40], legal[b], s[0]), 1'b0, 0);
      end
    end

    // Errors: illegal byte enables and out-of-range word index.
    doReq(1'b0, 12'h050, 4'b0101, 1'b1, 32'h0, 32'h0, 1'b1, 0);
    doReq(1'b1, 12'h400, 4'hF, 1'b0, 32'hBAD0BAD0, 32'h0, 1'b1, 0);
    doReq(1'b1, 12'h054, 4'b0110, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    doReq(1'b0, 12'hFFC, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    doReq(1'b1, 12'h058, 4'b0000, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      doReq(1'b0, 12'(i * 4), 4'hF, 1'b0, 32'h0, modelMem[i], 1'b0, 0);
    end

    // Backpressure: response held for five cycles while a new request waits.
    doReq(1'b0, 12'h010, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    doReq(1'b0, 12'h060, 4'hF, 1'b0, 32'h0, modelMem[24], 1'b0, 0);

    // Reset during the wait states of a store aborts it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h040; req_be = 4'hF;
    req_wdata = 32'h0BADF00D; req_signed = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(rdy), 32'd1);
    chk("abort_valid", 32'(rv), 32'd0);
    chk("abort_rdata", rd, 32'h0);
    chk("abort_err", 32'(er), 32'd0);
    rst = 1'b0;
    doReq(1'b0, 12'h040, 4'hF, 1'b0, 32'h0, 32'h12345678, 1'b0, 0);

    // Zero wait states: single-cycle latency.
    sel = 1'b1;
    doReq(1'b1, 12'h080, 4'hF, 1'b0, 32'hA5A55A5A, 32'h0, 1'b0, 0);
    doReq(1'b0, 12'h080, 4'hF, 1'b0, 32'h0, 32'hA5A55A5A, 1'b0, 0);
    doReq(1'b0, 12'h080, 4'b1100, 1'b1, 32'h0, 32'hFFFFA5A5, 1'b0, 0);
    doReq(1'b0, 12'h080, 4'b0001, 1'b0, 32'h0, 32'h0000005A, 1'b0, 0);
    doReq(1'b0, 12'h080, 4'b0110, 1'b0, 32'h0, 32'h0, 1'b1, 0);

    chk("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the multicycle CPU's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake and inserts a programmable number of wait states.
- Stores perform per-lane byte-enable writes. Loads return lane-extracted data, sign- or zero-extended.
- Sits between the CPU datapath's byte-enable/address logic and a word-organised storage array held inside the block.

Parameters:
- ADDR_W, 12, byte-address width of req_addr.
- DEPTH, 1024, number of 32-bit words stored; must be ≤ 2^(ADDR_W-2).
- WAIT_CYCLES, 2, wait states between request acceptance and response (0..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2].
- req_be  in  4  byte-lane enables; bit i = bits [8i+7:8i].
- req_signed  in  1  load result is sign-extended (1) or zero-extended (0).
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  load result, right-aligned and extended; 0 for stores and errors.
- resp_err  out  1  request rejected (illegal BE or word index ≥ DEPTH).

Behaviour:
- Reset: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
- Reset does not clear the storage array.
- States:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch all req_* fields and load the counter with WAIT_CYCLES. Go to WAIT, or directly to EXEC if WAIT_CYCLES = 0.
  - WAIT: req_ready = 0. Decrement the counter each cycle; go to EXEC when the counter reaches 1 on the decrement edge.
  - EXEC: one cycle. Perform the array access, register resp_rdata and resp_err, then go to RESP.
  - RESP: resp_valid = 1, outputs held stable. On resp_ready, go to IDLE.
- Timing:
  - Accept at edge N → resp_valid = 1 after edge N+WAIT_CYCLES+1.
  - Minimum occupancy is WAIT_CYCLES+3 cycles per transaction.
- req_ready is 0 from the accept edge until the cycle after the response handshake. Back-to-back acceptance in the same cycle as a response handshake is not supported.
- Legal BE values:
  - Bytes: 0001, 0010, 0100, 1000.
  - Halves: 0011, 1100.
  - Word: 1111.
- Any other BE value, or word index ≥ DEPTH, sets resp_err = 1, forces resp_rdata = 0, and suppresses the write.
- Store:
  - At the EXEC edge, each enabled lane is written from the right-aligned data: byte lane i ← wdata[7:0]; half at lanes 3:2 ← wdata[15:0]; word ← wdata.
  - Disabled lanes are unchanged. resp_rdata = 0.
- Load:
  - Extract the enabled lanes and shift them down to bit 0.
  - req_signed = 1: replicate bit 7 (byte) or bit 15 (half) into the upper bits. req_signed = 0: zero-fill.
  - Word loads ignore req_signed.
- req_* inputs are ignored while not in IDLE; changes to them mid-transaction have no effect.
- resp_ready is ignored outside RESP.
- Reset mid-transaction:
  - Asserted in WAIT: the transaction is aborted and no write occurs.
  - Asserted on the EXEC edge: reset wins and the write is suppressed.
  - Asserted in RESP: the completed write stands, and the response is dropped.
- resp_valid never deasserts without a handshake except on reset.

Test Plan:
- Word store/load: after reset, WAIT_CYCLES=2. Store addr 0x010, BE 1111, wdata 0xDEADBEEF → resp_valid exactly 3 cycles after accept, resp_err = 0. Then load addr 0x010, BE 1111 → resp_rdata 0xDEADBEEF.
- Byte merge and extension: store addr 0x020, BE 0100, wdata 0x000000F0 over a prior word 0x11223344 → word = 0x11F03344. Load BE 0100 signed → 0xFFFFFFF0; unsigned → 0x000000F0.
- Halfword: store addr 0x030, BE 1100, wdata 0x00008001 over 0 → word = 0x80010000. Load BE 1100 signed → 0xFFFF8001; load BE 0011 → 0x00000000.
- Errors: load with BE 0101 → resp_err = 1, rdata = 0. Store at word index DEPTH (DEPTH=256, addr 0x400, ADDR_W=12) → resp_err = 1, array unchanged (verify by reading every word).
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP → resp_valid, resp_rdata and resp_err are stable, req_ready = 0, and a new req_valid is not accepted. Release → IDLE and req_ready = 1 next cycle. With WAIT_CYCLES=0, latency = 1 cycle.
- Reset mid-operation: assert rst in WAIT during a store to 0x040 (old 0x12345678) → all outputs at reset values next cycle, and a subsequent load returns 0x12345678.
